// File: rtl/vga_frame_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_frame_gen_pkg
// Shared VGA 640x480@60 timing constants (pixel clocks / lines), the default
// split colours and small helpers used by the frame generator, the sync
// counter, the bar-position logic and the benches.
// No ports: package only.
// ---------------------------------------------------------------------------
package vga_frame_gen_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // One frame in pixel clocks (420000 for the defaults).
  localparam int FRAME_CLKS_DEF = H_TOTAL_DEF * V_TOTAL_DEF;

  // RGB333 colours, packed {red, green, blue}.
  localparam logic [8:0] TOP_COLOUR_DEF = 9'b111_000_000;
  localparam logic [8:0] BOT_COLOUR_DEF = 9'b000_000_111;
  localparam logic [8:0] BLACK          = 9'b000_000_000;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [2:0] blu;
  } rgb333_t;

  // Inclusive range test on a 10-bit coordinate.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Free-running horizontal / vertical raster counters plus the raw
// (unregistered) decode of sync and visible region from the counter state.
// Ports:
//   i_Clk        pixel clock
//   i_Reset      synchronous active-high reset, counters go to (0,0)
//   o_HCnt       horizontal counter, 0..H_TOTAL-1
//   o_VCnt       vertical counter, 0..V_TOTAL-1
//   o_HSyncRaw   active-low hsync decoded from o_HCnt
//   o_VSyncRaw   active-low vsync decoded from o_VCnt
//   o_ActiveRaw  high while (o_HCnt, o_VCnt) is in the visible region
// ---------------------------------------------------------------------------
module vga_sync_counter
  import vga_frame_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic [9:0] o_HCnt,
  output logic [9:0] o_VCnt,
  output logic       o_HSyncRaw,
  output logic       o_VSyncRaw,
  output logic       o_ActiveRaw
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = 10'd0;
      // The line counter only moves on the horizontal wrap.
      if (v_q == V_MAX) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Vsync decodes on the line counter alone, so it spans whole lines.
  always_comb begin
    o_HCnt      = h_q;
    o_VCnt      = v_q;
    o_HSyncRaw  = ~in_window(h_q, HS_FIRST, HS_LAST);
    o_VSyncRaw  = ~in_window(v_q, VS_FIRST, VS_LAST);
    o_ActiveRaw = (h_q < H_VIS) && (v_q < V_VIS);
  end

endmodule

// File: rtl/vga_frame_gen.sv
// ---------------------------------------------------------------------------
// vga_frame_gen
// VGA raster generator with a two-colour screen split at a programmable row.
// Every output is registered one clock after the counter state, so sync,
// active, colour and the reported coordinate all describe the same pixel.
// Ports:
//   i_Clk                pixel clock (25 MHz for the default timing)
//   i_Reset              synchronous active-high reset
//   i_VerticalSplitLine  split row; latched once per frame at (0,0)
//   o_NewFrameTick       one-clock pulse at the start of vertical blanking
//   o_HSync / o_VSync    active-low sync
//   o_Red/o_Grn/o_Blu    RGB333 pixel colour, 0 outside the visible region
//   o_Active             high while in the visible region
//   o_Col / o_Row        coordinate of the pixel on the outputs (raw counter
//                        values, also during blanking)
// ---------------------------------------------------------------------------
module vga_frame_gen
  import vga_frame_gen_pkg::*;
#(
  parameter int         H_ACTIVE   = H_ACTIVE_DEF,
  parameter int         H_FP       = H_FP_DEF,
  parameter int         H_SYNC     = H_SYNC_DEF,
  parameter int         H_BP       = H_BP_DEF,
  parameter int         V_ACTIVE   = V_ACTIVE_DEF,
  parameter int         V_FP       = V_FP_DEF,
  parameter int         V_SYNC     = V_SYNC_DEF,
  parameter int         V_BP       = V_BP_DEF,
  parameter logic [8:0] TOP_COLOUR = TOP_COLOUR_DEF,
  parameter logic [8:0] BOT_COLOUR = BOT_COLOUR_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [8:0] i_VerticalSplitLine,
  output logic       o_NewFrameTick,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [2:0] o_Red,
  output logic [2:0] o_Grn,
  output logic [2:0] o_Blu,
  output logic       o_Active,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row
);

  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       active_raw;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .o_HCnt      (h_cnt),
    .o_VCnt      (v_cnt),
    .o_HSyncRaw  (hsync_raw),
    .o_VSyncRaw  (vsync_raw),
    .o_ActiveRaw (active_raw)
  );

  logic       frame_start;
  logic [8:0] split_q, split_d;
  logic [8:0] split_eff;
  rgb333_t    colour_q, colour_d;
  logic       tick_q, tick_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;

  // The split row is only allowed to change at the very first pixel of a
  // frame, so a moving bar never tears mid-frame. That first pixel must
  // already use the freshly sampled value, hence split_eff.
  always_comb begin
    frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    split_d     = frame_start ? i_VerticalSplitLine : split_q;
    split_eff   = split_d;
  end

  always_comb begin
    colour_d = BLACK;
    if (active_raw) begin
      // Zero-extend the 9-bit split: values >= V_ACTIVE give an all-top frame.
      if (v_cnt < {1'b0, split_eff}) begin
        colour_d = TOP_COLOUR;
      end else begin
        colour_d = BOT_COLOUR;
      end
    end
    tick_d   = (h_cnt == 10'd0) && (v_cnt == V_VIS);
    hsync_d  = hsync_raw;
    vsync_d  = vsync_raw;
    active_d = active_raw;
    col_d    = h_cnt;
    row_d    = v_cnt;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      split_q  <= 9'd0;
      colour_q <= BLACK;
      tick_q   <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      col_q    <= 10'd0;
      row_q    <= 10'd0;
    end else begin
      split_q  <= split_d;
      colour_q <= colour_d;
      tick_q   <= tick_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  always_comb begin
    o_NewFrameTick = tick_q;
    o_HSync        = hsync_q;
    o_VSync        = vsync_q;
    o_Red          = colour_q.red;
    o_Grn          = colour_q.grn;
    o_Blu          = colour_q.blu;
    o_Active       = active_q;
    o_Col          = col_q;
    o_Row          = row_q;
  end

endmodule
